// File: rtl/program_loader.sv
// program_loader: receives a big-endian byte stream, assembles 32-bit
// instruction words and writes them into a CPU instruction memory while
// holding the CPU in reset. After the last word, CpuReset stays high for
// RST_HOLD cycles, then the CPU is released (RUN).
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the program. A mismatch parks the loader in ERROR
// with the sticky error flag set and the CPU held in reset.
//
// Parameters
//   WORDS    : instruction words per session (1..256)
//   RST_HOLD : cycles CpuReset stays high after the last write (1..15)
// Ports
//   clk, Reset        : clock, synchronous active-low reset
//   start             : one-cycle pulse, begins a session from IDLE/RUN/ERROR
//   in_data/in_valid  : byte stream in; in_ready is the accept handshake
//   LoadInstructions  : one-cycle write strobe; Instruction/load_addr valid
//   CpuReset          : active-high CPU reset (low only in RUN)
//   busy              : high outside IDLE and RUN
//   error             : sticky checksum failure
module program_loader #(
   parameter int WORDS    = 32,
   parameter int RST_HOLD = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        LoadInstructions,
   output logic [31:0] Instruction,
   output logic [7:0]  load_addr,
   output logic        CpuReset,
   output logic        busy,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CHECK   = 3'd3,
`endif
      HOLD    = 3'd4,
      RUN     = 3'd5,
      ERROR   = 3'd6
   } state_t;

   state_t      state, nxt;
   logic [31:0] word;
   logic [1:0]  byte_cnt;
   logic [8:0]  word_cnt;   // 9 bits so a full 256-word session can be counted
   logic [3:0]  hold_cnt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  xsum;
   logic        err;
`endif

   // next-state logic
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, RUN, ERROR: if (start) nxt = COLLECT;
         COLLECT: if (in_valid && byte_cnt == 2'd3) nxt = WRITE;
         WRITE: begin
            if (word_cnt == 9'(WORDS - 1)) begin
`ifdef LOADER_CHECKSUM_EN
               nxt = CHECK;
`else
               nxt = HOLD;
`endif
            end else begin
               nxt = COLLECT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: if (in_valid) nxt = (in_data == xsum) ? HOLD : ERROR;
`endif
         HOLD: if (hold_cnt == 4'(RST_HOLD - 1)) nxt = RUN;
         default: nxt = IDLE;
      endcase
   end

   // outputs are decoded from state so nothing strobes on a reset cycle
   always_comb begin
      in_ready         = (state == COLLECT);
`ifdef LOADER_CHECKSUM_EN
      if (state == CHECK) in_ready = 1'b1;
      error            = err;
`else
      error            = 1'b0;
`endif
      LoadInstructions = (state == WRITE);
      Instruction      = (state == WRITE) ? word : 32'd0;
      load_addr        = word_cnt[7:0];
      CpuReset         = (state != RUN);
      busy             = (state != IDLE) && (state != RUN);
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state    <= IDLE;
         word     <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
         hold_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
         xsum     <= '0;
         err      <= 1'b0;
`endif
      end else begin
         state <= nxt;
         unique case (state)
            IDLE, RUN, ERROR: begin
               if (start) begin
                  word     <= '0;
                  byte_cnt <= '0;
                  word_cnt <= '0;
                  hold_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                  xsum     <= '0;
                  err      <= 1'b0;
`endif
               end
            end
            COLLECT: begin
               if (in_valid) begin
                  word     <= {word[23:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 on the 4th byte
`ifdef LOADER_CHECKSUM_EN
                  xsum     <= xsum ^ in_data;
`endif
               end
            end
            WRITE: word_cnt <= word_cnt + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (in_valid && in_data != xsum) err <= 1'b1;
`endif
            HOLD: hold_cnt <= hold_cnt + 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Two instances share one stimulus:
// u_a (WORDS=2) for the functional cases and u_b (WORDS=256) for the
// full-size load. Expected values are hand-derived constants.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        Reset, start, in_valid;
   logic [7:0]  in_data;

   logic        rdy_a, li_a, cr_a, busy_a, err_a;
   logic [31:0] ins_a;
   logic [7:0]  addr_a;
   logic        rdy_b, li_b, cr_b, busy_b, err_b;
   logic [31:0] ins_b;
   logic [7:0]  addr_b;

   int nchk  = 0;
   int nfail = 0;
   logic [7:0] xs;   // running XOR of program bytes sent in this session

   always #5 clk = ~clk;

   program_loader #(.WORDS(2), .RST_HOLD(4)) u_a (
      .clk(clk), .Reset(Reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_a), .LoadInstructions(li_a),
      .Instruction(ins_a), .load_addr(addr_a), .CpuReset(cr_a),
      .busy(busy_a), .error(err_a));

   program_loader #(.WORDS(256), .RST_HOLD(4)) u_b (
      .clk(clk), .Reset(Reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_b), .LoadInstructions(li_b),
      .Instruction(ins_b), .load_addr(addr_b), .CpuReset(cr_b),
      .busy(busy_b), .error(err_b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      xs    = 8'h00;
      tick;
      start = 1'b0;
   endtask

   // Sends one word MSB first, optionally with an idle cycle before bytes
   // 2..4, then checks the write strobe and leaves the WRITE state.
   task automatic send_word(input logic [31:0] w, input logic [7:0] addr,
                            input bit gap, input bit big);
      for (int k = 0; k < 4; k++) begin
         if (gap && k > 0) begin
            in_valid = 1'b0;
            tick;
            chk("gap_ready", rdy_a, 1);
            chk("gap_nostrobe", li_a, 0);
         end
         in_valid = 1'b1;
         in_data  = w[31 - 8*k -: 8];
         xs       = xs ^ in_data;
         tick;
      end
      in_valid = 1'b0;
      chk("strobe", big ? li_b : li_a, 1);
      chk("instr", big ? ins_b : ins_a, w);
      chk("addr", big ? addr_b : addr_a, {24'd0, addr});
      chk("write_notready", big ? rdy_b : rdy_a, 0);
      tick;
   endtask

   // From just after the last WRITE: optional checksum, then RST_HOLD
   // cycles of CpuReset high, then RUN.
   task automatic finish_session(input logic [7:0] cks, input bit big);
`ifdef LOADER_CHECKSUM_EN
      in_valid = 1'b1;
      in_data  = cks;
      tick;
      in_valid = 1'b0;
`else
      if (cks != xs) $display("note: checksum byte unused in this build");
`endif
      for (int h = 0; h < 4; h++) begin
         chk("hold_cpureset", big ? cr_b : cr_a, 1);
         chk("hold_busy", big ? busy_b : busy_a, 1);
         tick;
      end
      chk("run_cpureset", big ? cr_b : cr_a, 0);
      chk("run_busy", big ? busy_b : busy_a, 0);
      chk("run_error", big ? err_b : err_a, 0);
   endtask

   task automatic chk_reset_outputs;
      chk("rst_ready", rdy_a, 0);
      chk("rst_strobe", li_a, 0);
      chk("rst_instr", ins_a, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_cpureset", cr_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_error", err_a, 0);
   endtask

   initial begin
      Reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; xs = 8'h00;
      tick; tick;
      chk_reset_outputs();
      Reset = 1'b1;
      tick;
      chk("idle_cpureset", cr_a, 1);

      // basic two-word load
      pulse_start();
      chk("collect_ready", rdy_a, 1);
      chk("collect_busy", busy_a, 1);
      send_word(32'h20080005, 8'd0, 1'b0, 1'b0);
      send_word(32'h20090007, 8'd1, 1'b0, 1'b0);
      finish_session(xs, 1'b0);

      // RUN ignores bytes
      in_valid = 1'b1; in_data = 8'hEE;
      tick;
      chk("run_notready", rdy_a, 0);
      chk("run_nostrobe", li_a, 0);
      chk("run_stays", cr_a, 0);
      in_valid = 1'b0;

      // start in RUN: CpuReset next cycle, reload from addr 0 with gaps
      pulse_start();
      chk("restart_cpureset", cr_a, 1);
      chk("restart_addr", addr_a, 0);
      send_word(32'h20080005, 8'd0, 1'b1, 1'b0);
      send_word(32'h20090007, 8'd1, 1'b1, 1'b0);
      finish_session(xs, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      // wrong checksum -> ERROR, later start clears it
      pulse_start();
      send_word(32'h20080005, 8'd0, 1'b0, 1'b0);
      send_word(32'h20090007, 8'd1, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = xs ^ 8'hFF;
      tick;
      in_valid = 1'b0;
      chk("err_flag", err_a, 1);
      chk("err_cpureset", cr_a, 1);
      tick; tick;
      chk("err_sticky", err_a, 1);
      pulse_start();
      chk("err_cleared", err_a, 0);
      send_word(32'h01020304, 8'd0, 1'b0, 1'b0);
      send_word(32'h05060708, 8'd1, 1'b0, 1'b0);
      finish_session(xs, 1'b0);
`endif

      // reset mid-session after 2 bytes of word 1
      pulse_start();
      send_word(32'hCAFEF00D, 8'd0, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 8'hAA; tick;
      in_data = 8'hBB; tick;
      in_valid = 1'b0;
      Reset = 1'b0;
      tick;
      chk_reset_outputs();
      Reset = 1'b1;
      tick;
      pulse_start();
      send_word(32'h11223344, 8'd0, 1'b0, 1'b0);

      // start pulsed in COLLECT together with a byte: ignored, word intact
      in_valid = 1'b1; in_data = 8'h55; xs = xs ^ 8'h55; tick;
      in_data = 8'h66; xs = xs ^ 8'h66; tick;
      start = 1'b1; in_data = 8'h77; xs = xs ^ 8'h77; tick;
      start = 1'b0; in_data = 8'h88; xs = xs ^ 8'h88; tick;
      in_valid = 1'b0;
      chk("collect_start_strobe", li_a, 1);
      chk("collect_start_instr", ins_a, 32'h55667788);
      chk("collect_start_addr", addr_a, 1);
      tick;
      finish_session(xs, 1'b0);

      // full 256-word load on u_b; word i is {i,i,i,i} so its XOR is 0
      Reset = 1'b0; tick; Reset = 1'b1; tick;
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         send_word({4{8'(i)}}, 8'(i), 1'b0, 1'b1);
      end
      chk("full_xsum_model", xs, 0);
      finish_session(8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
